// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and widths for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int LEN_W          = 16;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles big-endian words from accepted bytes and keeps the running XOR
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        data_byte,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic [7:0]        xor_acc
);

    logic [1:0] cnt;

    // Shift bytes in MSB-first; pulse word_valid the cycle after the last byte of a word
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt        <= '0;
            word       <= '0;
            xor_acc    <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_en && cnt == 2'(BYTES_PER_WORD - 1);
            if (byte_en) begin
                cnt     <= cnt + 2'd1;
                word    <= {word[WORD_W-9:0], data_byte};
                xor_acc <= xor_acc ^ data_byte;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that writes instruction memory and holds the CPU until a good load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    localparam int IDX_W = $clog2(DEPTH) + 1;

    state_t           state;
    logic [LEN_W-1:0] n;
    logic [IDX_W-1:0] idx;
    logic [LEN_W-1:0] len_next;
    logic [7:0]       xor_acc;
    logic             accept;
    logic             launch;

    assign accept   = in_valid && in_ready;
    assign launch   = start && (state == IDLE || state == DONE || state == ERROR);
    assign in_ready = state == LEN_HI || state == LEN_LO || state == CHECK || (state == DATA && !wr_en);
    assign len_next = {n[LEN_W-1 -: 8], in_data};
    assign wr_addr  = BASE_ADDR + (WORD_W'(idx) << 2);

    imem_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (launch),
        .byte_en   (accept && state == DATA),
        .data_byte (in_data),
        .word_valid(wr_en),
        .word      (wr_data),
        .xor_acc   (xor_acc)
    );

    // Frame sequencing, word index and sticky status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            n        <= '0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE, ERROR: if (start) begin
                    state    <= LEN_HI;
                    idx      <= '0;
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    error    <= 1'b0;
                    cpu_hold <= 1'b1;
                end
                LEN_HI: if (accept) begin
                    n[LEN_W-1 -: 8] <= in_data;
                    state           <= LEN_LO;
                end
                LEN_LO: if (accept) begin
                    n[7:0] <= in_data;
                    if (len_next > LEN_W'(DEPTH)) begin
                        state <= ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= len_next == '0 ? CHECK : DATA;
                    end
                end
                DATA: if (wr_en) begin
                    idx <= idx + 1'b1;
                    if (LEN_W'(idx) + LEN_W'(1) == n) state <= CHECK;
                end
                CHECK: if (accept) begin
                    state    <= in_data == xor_acc ? DONE : ERROR;
                    done     <= in_data == xor_acc;
                    error    <= in_data != xor_acc;
                    cpu_hold <= in_data != xor_acc;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frame vectors plus hand-written corner sequences for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] words[$];
    int          dbl;
    logic        prev_wr;

    typedef struct {
        logic [15:0]      n;
        logic [3:0][31:0] w;
        logic [7:0]       flip;
        bit               gap;
        bit               ok;
    } vec_t;

    vec_t vt[6];

    imem_loader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    // Log every write and count wr_en pulses longer than one cycle
    always @(negedge clk) begin
        if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            if (prev_wr) dbl++;
        end
        prev_wr = wr_en;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int t;
        if (gap && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            nvec++;
            nerr++;
            $display("FAIL accept timeout: in_ready stayed 0, expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic frame(input logic [15:0] n, input logic [7:0] flip, input bit gap, input bit ok, input int mid_start);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] w;
        wa.delete();
        wd.delete();
        dbl = 0;
        x = flip;
        pulse_start();
        send(n[15:8], gap);
        send(n[7:0], gap);
        for (int i = 0; i < int'(n); i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                if (mid_start == 4 * i + k) pulse_start();
                b = w[31 - 8 * k -: 8];
                x ^= b;
                send(b, gap);
            end
        end
        chk("busy before chk", {31'd0, busy}, 32'd1);
        chk("hold before chk", {31'd0, cpu_hold}, 32'd1);
        send(x, gap);
        chk("done", {31'd0, done}, {31'd0, ok});
        chk("error", {31'd0, error}, {31'd0, !ok});
        chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, !ok});
        chk("busy after", {31'd0, busy}, 32'd0);
        chk("in_ready after", {31'd0, in_ready}, 32'd0);
        chk("write count", wa.size(), 32'(n));
        for (int i = 0; i < int'(n) && i < wa.size(); i++) begin
            chk("wr_addr", wa[i], 32'(4 * i));
            chk("wr_data", wd[i], words[i]);
        end
        chk("wr_en pulse width", dbl, 32'd0);
    endtask

    initial begin
        vt[0] = '{16'd3, {32'h0, 32'h1000_FFFF, 32'h2021_0001, 32'h2001_0000}, 8'h00, 1'b0, 1'b1};
        vt[1] = '{16'd3, {32'h0, 32'h1000_FFFF, 32'h2021_0001, 32'h2001_0000}, 8'h01, 1'b0, 1'b0};
        vt[2] = '{16'd0, {32'h0, 32'h0, 32'h0, 32'h0}, 8'h00, 1'b0, 1'b1};
        vt[3] = '{16'd0, {32'h0, 32'h0, 32'h0, 32'h0}, 8'h5A, 1'b0, 1'b0};
        vt[4] = '{16'd2, {32'h0, 32'h0, 32'h0123_4567, 32'hDEAD_BEEF}, 8'h00, 1'b0, 1'b1};
        vt[5] = '{16'd2, {32'h0, 32'h0, 32'h0123_4567, 32'hDEAD_BEEF}, 8'h00, 1'b1, 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        prev_wr  = 1'b0;
        dbl      = 0;
        repeat (2) @(negedge clk);
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst wr_addr", wr_addr, 32'h0);
        chk("rst wr_data", wr_data, 32'h0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst error", {31'd0, error}, 32'd0);
        chk("rst cpu_hold", {31'd0, cpu_hold}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            words.delete();
            for (int i = 0; i < int'(vt[v].n); i++) words.push_back(vt[v].w[i]);
            frame(vt[v].n, vt[v].flip, vt[v].gap, vt[v].ok, -1);
        end

        // Oversized length: rejected right after LEN_LO with nothing written
        wa.delete();
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        chk("n257 error", {31'd0, error}, 32'd1);
        chk("n257 done", {31'd0, done}, 32'd0);
        chk("n257 busy", {31'd0, busy}, 32'd0);
        chk("n257 cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("n257 in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hAB;
        repeat (3) @(negedge clk);
        chk("n257 in_ready later", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        chk("n257 writes", wa.size(), 32'd0);

        // Full-depth load
        words.delete();
        for (int i = 0; i < 256; i++) words.push_back(32'h0101_0101 * i ^ 32'hA5C3_0000);
        frame(16'd256, 8'h00, 1'b0, 1'b1, -1);
        chk("n256 last addr", wa.size() > 0 ? wa[wa.size() - 1] : 32'hFFFF_FFFF, 32'h0000_03FC);

        // Reset after six data bytes, then a load with an ignored mid-DATA start
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        for (int k = 0; k < 6; k++) send(8'h10 + 8'(k), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst wr_en", {31'd0, wr_en}, 32'd0);
        chk("midrst wr_addr", wr_addr, 32'h0);
        words.delete();
        words.push_back(32'hCAFE_F00D);
        words.push_back(32'h1357_9BDF);
        frame(16'd2, 8'h00, 1'b0, 1'b1, 2);

        // Reset wins over a coincident start
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        chk("rst+start busy", {31'd0, busy}, 32'd0);
        chk("rst+start done", {31'd0, done}, 32'd0);
        chk("rst+start in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst+start cpu_hold", {31'd0, cpu_hold}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writes programs into instruction memory; it is the write-side counterpart of the word-aligned, read-only fetch port.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Drives a one-word-per-pulse write port into instruction memory.
- Holds the CPU via cpu_hold until a load completes with a good checksum.

Parameters:
- DEPTH, 256, number of 32-bit words in instruction memory (1 KB).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; word-aligned.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse that begins a new load
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  32  byte address, always word-aligned (bits [1:0]=0)
- wr_data  out  32  word to write
- busy  out  1  load in progress
- done  out  1  last load succeeded; sticky until the next start
- error  out  1  last load failed; sticky until the next start
- cpu_hold  out  1  keep CPU in reset/stall

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-low (rst_n sampled on the rising clk edge).
- Reset values: state=IDLE, in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, done=0, error=0, cpu_hold=1.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes, then CHK.
  - CHK is the XOR of all 4*N data bytes; length bytes are excluded.
  - The first data byte of each word goes to [31:24], the last to [7:0].
- Handshake: a byte is accepted on a cycle where in_valid && in_ready.
  - in_ready=1 in LEN_HI, LEN_LO, DATA and CHECK; 0 otherwise.
  - Gaps in in_valid only stall the loader; no state is lost.
- State machine:
  - IDLE/DONE/ERROR: on start, go to LEN_HI; clear done, error and the word index; set cpu_hold=1 and busy=1.
  - LEN_HI: accept byte into N[15:8], go to LEN_LO.
  - LEN_LO: accept byte into N[7:0].
    - If N > DEPTH: go to ERROR (error=1, busy=0, cpu_hold stays 1); remaining stream bytes are not accepted.
    - If N == 0: go to CHECK.
    - Otherwise: go to DATA.
  - DATA: accept bytes into a 2-bit byte counter and shift register.
    - On the 4th accepted byte, on the next cycle: wr_en=1 for exactly one cycle, wr_data = assembled word, wr_addr = BASE_ADDR + 4*index.
    - index then increments.
    - After word N-1 is written, go to CHECK.
  - CHECK: accept one byte.
    - Match with the running XOR: go to DONE (done=1, busy=0, cpu_hold=0).
    - Mismatch: go to ERROR (error=1, busy=0, cpu_hold=1).
    - Words already written are not rolled back.
- Latency: last byte of a word accepted in cycle t -> wr_en asserted in cycle t+1. No further byte is accepted in cycle t+1 (in_ready=0 while the write is issued), so at most one write is outstanding.
- index width is clog2(DEPTH)+1; the address never wraps because N <= DEPTH is checked first.
- start while busy is ignored.
- start in the same cycle as rst_n=0: reset wins.
- Reset mid-load: returns to IDLE with cpu_hold=1. Any in-flight wr_en is dropped on that edge; partial memory contents are left as written.
- cpu_hold deasserts only on a successful DONE. It stays 0 in DONE until the next start.

Decomposition:
- Package imem_loader_pkg:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR)
  - LEN_W=16, WORD_W=32, BYTES_PER_WORD=4
- Sub-module imem_word_packer:
  - byte counter, big-endian shift register and running XOR
  - outputs word_valid (pulse), word and xor_acc
  - clear input driven on start and reset
- Top level holds the FSM, the index/address counter and the status flags.

Test Plan:
- Load N=3, words 0x2001_0000, 0x2021_0001, 0x1000_FFFF with correct CHK -> three wr_en pulses at addresses 0x0, 0x4, 0x8 with those data; done=1, error=0, cpu_hold falls the cycle after CHK is accepted.
- Same frame with CHK XOR 0x01 -> three writes occur, then error=1, done=0, cpu_hold stays 1.
- N=0, CHK=0x00 -> no wr_en, done=1. N=0, CHK=0x5A -> error=1.
- N=257 (LEN 0x01,0x01) with DEPTH=256 -> error=1 immediately after LEN_LO, in_ready=0, no writes. N=256 -> last wr_addr=0x3FC.
- Random in_valid gaps (about 50% duty) on a 2-word load -> identical writes and addresses to the gap-free run; each wr_en lasts exactly one cycle.
- rst_n low for 1 cycle after 6 data bytes -> IDLE, cpu_hold=1, in_ready=0; a start pulse during the next load's DATA is ignored; a fresh load after reset succeeds.
